// File: rtl/vc_fifo.sv
// vc_fifo: per-virtual-channel synchronous FIFO for the transaction layer.
// Buffers LINE_SIZE-bit lines in a DEPTH-entry array and decodes occupancy
// flags from a registered count. Read data is registered and comes with a
// one-cycle valid strobe.
// Optional feature macro: VC_FIFO_ERR_EN adds a sticky overflow/underflow
// error register. Without it, `error` is tied low and no register exists.
module vc_fifo #(
  parameter int LINE_SIZE = 12,
  parameter int DEPTH     = 8,
  parameter int AF_TH     = 6,
  parameter int AE_TH     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [LINE_SIZE-1:0]     data_in,
  output logic [LINE_SIZE-1:0]     data_out,
  output logic                     valid_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_TH);

  logic [LINE_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count_q;

  logic [LINE_SIZE-1:0] rd_data_p1;
  logic                 vld_p1;

  logic full_w;
  logic empty_w;
  logic push_ok;
  logic pop_ok;

  // Flags are pure decodes of the registered count, so they move on the same
  // edge as the count itself.
  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A pop is legal whenever something is stored. A push into a full FIFO is
  // legal only when a pop frees a slot on the same edge. No bypass from
  // data_in to data_out: a push+pop on empty rejects the pop.
  assign pop_ok  = pop && !empty_w;
  assign push_ok = push && (!full_w || pop_ok);

  // ---- stage p0: storage write (memory is never reset)
  // Capture the incoming line at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---- stage p1: registered read data and its one-cycle valid strobe
  // data_out holds its last value when no pop is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= pop_ok;
      if (pop_ok) begin
        rd_data_p1 <= mem[rd_ptr];
      end
    end
  end

`ifdef VC_FIFO_ERR_EN
  logic ovf_evt;
  logic udf_evt;
  logic err_q;

  assign ovf_evt = push && !push_ok;
  assign udf_evt = pop && !pop_ok;

  // Sticky error: any dropped push or ignored pop latches it until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (ovf_evt || udf_evt) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign data_out     = rd_data_p1;
  assign valid_out    = vld_p1;
  assign count        = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: table-driven vectors for fill/drain plus hand-written sequences
// for full/empty corner cases and mid-operation asynchronous reset.
module tb_vc_fifo;

  localparam int LW = 12;
  localparam int CW = 4;

`ifdef VC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic [LW-1:0] data_in;
  logic [LW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          error;

  vc_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic          pop;
    logic [LW-1:0] din;
    logic          ev;
    logic [LW-1:0] ed;
    logic [CW-1:0] ec;
    logic          ef;
    logic          ee;
    logic          eaf;
    logic          eae;
  } vec_t;

  vec_t vecs[16];

  int n_checks;
  int n_fail;
  logic [LW-1:0] last_out;
  logic          exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, then check everything right after the edge. Flags are
  // modelled from the expected count; data_out is modelled as holding.
  task automatic step(input logic p, input logic q, input logic [LW-1:0] d,
                      input logic ev, input logic [LW-1:0] ed, input int ec,
                      input string tag);
    @(negedge clk);
    push = p; pop = q; data_in = d;
    @(posedge clk);
    #1;
    if (ev) last_out = ed;
    chk({tag, ".valid"}, 32'(valid_out), 32'(ev));
    chk({tag, ".data"},  32'(data_out),  32'(last_out));
    chk({tag, ".count"}, 32'(count),     32'(ec));
    chk({tag, ".full"},  32'(full),      32'(ec == 8));
    chk({tag, ".empty"}, 32'(empty),     32'(ec == 0));
    chk({tag, ".af"},    32'(almost_full),  32'(ec >= 6));
    chk({tag, ".ae"},    32'(almost_empty), 32'(ec <= 2));
    chk({tag, ".error"}, 32'(error),     32'(exp_err));
  endtask

  function automatic vec_t mk(input logic p, input logic q, input logic [LW-1:0] d,
                              input logic ev, input logic [LW-1:0] ed, input logic [CW-1:0] ec,
                              input logic ef, input logic ee, input logic eaf, input logic eae);
    vec_t v;
    v.push = p; v.pop = q; v.din = d; v.ev = ev; v.ed = ed; v.ec = ec;
    v.ef = ef; v.ee = ee; v.eaf = eaf; v.eae = eae;
    return v;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, ".count"}, 32'(count),        32'd0);
    chk({tag, ".empty"}, 32'(empty),        32'd1);
    chk({tag, ".ae"},    32'(almost_empty), 32'd1);
    chk({tag, ".full"},  32'(full),         32'd0);
    chk({tag, ".af"},    32'(almost_full),  32'd0);
    chk({tag, ".data"},  32'(data_out),     32'd0);
    chk({tag, ".valid"}, 32'(valid_out),    32'd0);
    chk({tag, ".error"}, 32'(error),        32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_out = '0;
    exp_err  = 1'b0;
    push = 1'b0; pop = 1'b0; data_in = '0;

    //        push pop din     ev  ed      cnt  full empty af ae
    vecs[0]  = mk(1, 0, 12'h001, 0, 12'h000, 4'd1, 0, 0, 0, 1);
    vecs[1]  = mk(1, 0, 12'h002, 0, 12'h000, 4'd2, 0, 0, 0, 1);
    vecs[2]  = mk(1, 0, 12'h003, 0, 12'h000, 4'd3, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 12'h004, 0, 12'h000, 4'd4, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 12'h005, 0, 12'h000, 4'd5, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 12'h006, 0, 12'h000, 4'd6, 0, 0, 1, 0);
    vecs[6]  = mk(1, 0, 12'h007, 0, 12'h000, 4'd7, 0, 0, 1, 0);
    vecs[7]  = mk(1, 0, 12'h008, 0, 12'h000, 4'd8, 1, 0, 1, 0);
    vecs[8]  = mk(0, 1, 12'h000, 1, 12'h001, 4'd7, 0, 0, 1, 0);
    vecs[9]  = mk(0, 1, 12'h000, 1, 12'h002, 4'd6, 0, 0, 1, 0);
    vecs[10] = mk(0, 1, 12'h000, 1, 12'h003, 4'd5, 0, 0, 0, 0);
    vecs[11] = mk(0, 1, 12'h000, 1, 12'h004, 4'd4, 0, 0, 0, 0);
    vecs[12] = mk(0, 1, 12'h000, 1, 12'h005, 4'd3, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 12'h000, 1, 12'h006, 4'd2, 0, 0, 0, 1);
    vecs[14] = mk(0, 1, 12'h000, 1, 12'h007, 4'd1, 0, 0, 0, 1);
    vecs[15] = mk(0, 1, 12'h000, 1, 12'h008, 4'd0, 0, 1, 0, 1);

    // Reset is asynchronous: outputs must be at reset values before any edge.
    reset = 1'b0;
    #1;
    chk_reset_state("reset0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Fill 8 then drain 8, checking ordering, latency and every flag.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      push = vecs[i].push; pop = vecs[i].pop; data_in = vecs[i].din;
      @(posedge clk);
      #1;
      if (vecs[i].ev) last_out = vecs[i].ed;
      chk($sformatf("vec%0d.valid", i), 32'(valid_out),    32'(vecs[i].ev));
      chk($sformatf("vec%0d.data", i),  32'(data_out),     32'(vecs[i].ed));
      chk($sformatf("vec%0d.count", i), 32'(count),        32'(vecs[i].ec));
      chk($sformatf("vec%0d.full", i),  32'(full),         32'(vecs[i].ef));
      chk($sformatf("vec%0d.empty", i), 32'(empty),        32'(vecs[i].ee));
      chk($sformatf("vec%0d.af", i),    32'(almost_full),  32'(vecs[i].eaf));
      chk($sformatf("vec%0d.ae", i),    32'(almost_empty), 32'(vecs[i].eae));
      chk($sformatf("vec%0d.error", i), 32'(error),        32'd0);
    end

    // Full with simultaneous push+pop: both accepted, count stays 8.
    for (int i = 0; i < 8; i++)
      step(1, 0, 12'h011 + 12'(i), 0, 12'h000, i + 1, "fillA");
    step(1, 1, 12'hABC, 1, 12'h011, 8, "fullpp");
    for (int i = 0; i < 7; i++)
      step(0, 1, 12'h000, 1, 12'h012 + 12'(i), 7 - i, "drainA");
    step(0, 1, 12'h000, 1, 12'hABC, 0, "drainA.abc");

    // Overflow: push into full with no pop is dropped.
    for (int i = 0; i < 8; i++)
      step(1, 0, 12'h021 + 12'(i), 0, 12'h000, i + 1, "fillB");
    exp_err = ERR_EN;
    step(1, 0, 12'hFFF, 0, 12'h000, 8, "ovf");
    for (int i = 0; i < 8; i++)
      step(0, 1, 12'h000, 1, 12'h021 + 12'(i), 7 - i, "drainB");

    // Underflow with simultaneous push on empty: push kept, pop rejected.
    step(1, 1, 12'h123, 0, 12'h000, 1, "emptypp");
    step(0, 1, 12'h000, 1, 12'h123, 0, "emptypp.pop");

    // Wrap the write pointer, leave 5 lines, then reset between edges.
    for (int i = 0; i < 8; i++)
      step(1, 0, 12'h031 + 12'(i), 0, 12'h000, i + 1, "fillC");
    for (int i = 0; i < 3; i++)
      step(0, 1, 12'h000, 1, 12'h031 + 12'(i), 7 - i, "drainC");
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("midreset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    last_out = '0;
    exp_err  = 1'b0;
    step(1, 0, 12'h5A5, 0, 12'h000, 1, "post.push");
    step(0, 1, 12'h000, 1, 12'h5A5, 0, "post.pop");

    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_fifo.md
# vc_fifo

Per-virtual-channel synchronous FIFO for the transaction layer; four instances sit directly downstream of the class-routing referee, which drives `push` and `data_in` and watches `almost_full`. The egress referee drains it via `pop` and `almost_empty`. It buffers 12-bit transaction lines and provides occupancy flags with parameterised thresholds, registered read data and sticky error reporting.

## Interface
- `LINE_SIZE`, 12, width of one stored line in bits
- `DEPTH`, 8, number of entries; power of two, minimum 4
- `AF_TH`, 6, `almost_full` asserts when count >= AF_TH; legal range 1..DEPTH
- `AE_TH`, 2, `almost_empty` asserts when count <= AE_TH; legal range 0..DEPTH-1

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `push`  in  1  write request; `data_in` is captured on the same edge
- `pop`  in  1  read request
- `data_in`  in  LINE_SIZE  line to store
- `data_out`  out  LINE_SIZE  registered read data
- `valid_out`  out  1  high for exactly one cycle when `data_out` carries a newly popped line
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count >= AF_TH
- `almost_empty`  out  1  count <= AE_TH
- `count`  out  clog2(DEPTH)+1  current occupancy
- `error`  out  1  sticky overflow/underflow flag (see Configuration)

## Operation
- Storage: DEPTH x LINE_SIZE array. Write and read pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH. `count` is kept as a separate register; pointers carry no extra wrap bit.
- Push is accepted when `push` is high and either (not full) or (full and an accepted pop occurs in the same cycle). On acceptance: mem[wr_ptr] <= data_in, wr_ptr++.
- Pop is accepted when `pop` is high and the FIFO is not empty. On acceptance: data_out <= mem[rd_ptr], rd_ptr++, valid_out <= 1.
- When no pop is accepted: valid_out <= 0 and data_out holds its previous value.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push and pop in the same cycle when empty: the push is stored, the pop is rejected as an underflow. There is no write-to-read bypass.
- Push and pop in the same cycle when full: both are accepted and count stays at DEPTH.
- Rejected push (full, no pop): data is dropped and the overflow event fires. Rejected pop (empty): it is ignored and the underflow event fires.
- Flags `full`, `empty`, `almost_full` and `almost_empty` are combinational decodes of the registered `count`. They therefore reflect state after the edge, with no extra lag.

## Timing
- Reset (asynchronous assert, synchronous release on the next edge) sets all of the following: pointers = 0, count = 0, data_out = 0, valid_out = 0, error = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0 (given AF_TH >= 1). Memory contents are not cleared.
- Reset mid-operation discards all stored lines immediately. Outputs take their reset values without waiting for a clock edge.
- Write latency: a line pushed at edge N can be popped at edge N+1 at the earliest. It appears on `data_out` with `valid_out` high after edge N+1.
- Read latency: one cycle from the accepted pop edge to data on `data_out`.
- Flag latency: a flag changes on the same edge that changes `count`. Upstream must sample `almost_full` and stop pushing with at least DEPTH-AF_TH lines of slack.

## Configuration
- `VC_FIFO_ERR_EN` defined:
  - `error` is a sticky register.
  - It is set on the edge of any overflow or underflow event and stays high until reset.
- `VC_FIFO_ERR_EN` undefined:
  - `error` is tied to 0 and no error register is synthesised.
  - Drop/ignore behaviour on overflow and underflow is unchanged.

## Test plan
- Reset, then push 8 lines 0x001..0x008 and pop 8. Required: `data_out` sequence 0x001..0x008, each with `valid_out` one cycle after its pop. Count goes 0→8→0. `full` is high after push 8; `empty` is high after pop 8.
- With defaults, push 6 lines. Required: `almost_full` rises on the edge of push 6 (count 6); `almost_empty` falls on push 3 (count 3).
- Fill to 8, then issue push 0xABC plus pop in the same cycle. Required: count stays 8, the oldest line is output, and 0xABC is read out 8th afterwards. `error` stays 0.
- Fill to 8, push 0xFFF with no pop. Required: line dropped, count 8. `error` is 1 with `VC_FIFO_ERR_EN` and 0 without it.
- From empty, issue push 0x123 plus pop in the same cycle. Required: no `valid_out`, count 1, `error` set (with the macro). Popping next cycle returns 0x123.
- With 5 lines stored and pointers wrapped past index 7, assert `reset` low between edges. Required: immediate count 0, `empty` 1, `data_out` 0. After release, a subsequent push then pop returns the new line.
